// File: rtl/cam_pkg.sv
// Shared types for the CAM controller: request opcodes, FSM states and index sizing.
package cam_pkg;

    typedef enum logic [1:0] {
        OP_SEARCH = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELETE = 2'b10,
        OP_FLUSH  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MATCH  = 2'b01,
        COMMIT = 2'b10
    } state_e;

    // Index width for an array of depth entries; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder: returns the index of the lowest set bit and whether any bit is set.
module cam_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last assignment.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

endmodule

// File: rtl/cam_mem_ctrl.sv
// CAM controller: DEPTH key/data entries with search, write, delete and flush, one op per 3 cycles.
// Handshake: req is sampled only while busy=0; an accepted op runs IDLE->MATCH->COMMIT and results appear after COMMIT.
module cam_mem_ctrl
    import cam_pkg::*;
#(
    parameter int WIDTH_KEY    = 8,
    parameter int WIDTH_DATA   = 16,
    parameter int DEPTH        = 16,
    parameter int AFULL_THRESH = 2,
    parameter int REPLACE_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    input  logic [1:0]                   op,
    input  logic [WIDTH_KEY-1:0]         key,
    input  logic [WIDTH_DATA-1:0]        din,
    output logic [WIDTH_DATA-1:0]        dout,
    output logic                         read_valid,
    output logic                         hit,
    output logic [idx_width(DEPTH)-1:0]  hit_index,
    output logic                         busy,
    output logic                         full,
    output logic                         almost_full,
    output logic                         write_error,
    output logic                         invalid_write_state,
    output logic [1:0]                   state_dbg
);

    localparam int IW = idx_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic AF_RESET = (DEPTH <= AFULL_THRESH);

    state_e                 state_q, state_d;
    op_e                    op_q;
    logic [WIDTH_KEY-1:0]   key_q;
    logic [WIDTH_DATA-1:0]  din_q;

    logic [WIDTH_KEY-1:0]   keys_q [DEPTH];
    logic [WIDTH_DATA-1:0]  data_q [DEPTH];
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       match_q, cmp;
    logic [CW-1:0]          count_q, count_d;
    logic [IW-1:0]          victim_q, victim_d;

    logic [IW-1:0]          hit_idx, free_idx, wr_idx;
    logic                   hit_any, free_any;
    logic                   wr_en, clr_en, flush_en, search_done, werr_d, inv_d;
    logic                   full_d, af_d;

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = MATCH;
            MATCH:   state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cmp[i] = valid_q[i] && (keys_q[i] == key_q);
        end
    end

    cam_prio_enc #(.N(DEPTH), .W(IW)) u_hit_enc (
        .vec (match_q),
        .idx (hit_idx),
        .any (hit_any)
    );

    cam_prio_enc #(.N(DEPTH), .W(IW)) u_free_enc (
        .vec (~valid_q),
        .idx (free_idx),
        .any (free_any)
    );

    // Commit decode: what the COMMIT cycle does to storage, count and result pulses.
    always_comb begin
        count_d     = count_q;
        victim_d    = victim_q;
        wr_en       = 1'b0;
        wr_idx      = hit_idx;
        clr_en      = 1'b0;
        flush_en    = 1'b0;
        search_done = 1'b0;
        werr_d      = 1'b0;
        inv_d       = 1'b0;
        if (state_q == COMMIT) begin
            case (op_q)
                OP_SEARCH: search_done = 1'b1;
                OP_WRITE: begin
                    if (hit_any) begin
                        wr_en = 1'b1;
                    end else if (free_any) begin
                        wr_en   = 1'b1;
                        wr_idx  = free_idx;
                        count_d = count_q + CW'(1);
                    end else if (REPLACE_MODE != 0) begin
                        wr_en    = 1'b1;
                        wr_idx   = victim_q;
                        victim_d = (victim_q == IW'(DEPTH - 1)) ? '0 : victim_q + IW'(1);
                    end else begin
                        werr_d = 1'b1;
                    end
                end
                OP_DELETE: begin
                    if (hit_any) begin
                        clr_en  = 1'b1;
                        count_d = count_q - CW'(1);
                    end else begin
                        inv_d = 1'b1;
                    end
                end
                OP_FLUSH: begin
                    flush_en = 1'b1;
                    count_d  = '0;
                    victim_d = '0;
                end
                default: ;
            endcase
        end
        full_d = (count_d == CW'(DEPTH));
        af_d   = ((DEPTH - int'(count_d)) <= AFULL_THRESH);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q             <= IDLE;
            op_q                <= OP_SEARCH;
            key_q               <= '0;
            din_q               <= '0;
            valid_q             <= '0;
            match_q             <= '0;
            count_q             <= '0;
            victim_q            <= '0;
            dout                <= '0;
            read_valid          <= 1'b0;
            hit                 <= 1'b0;
            hit_index           <= '0;
            write_error         <= 1'b0;
            invalid_write_state <= 1'b0;
            full                <= 1'b0;
            almost_full         <= AF_RESET;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                op_q  <= op_e'(op);
                key_q <= key;
                din_q <= din;
            end
            if (state_q == MATCH) match_q <= cmp;

            if (flush_en) begin
                valid_q <= '0;
            end else begin
                if (wr_en)  valid_q[wr_idx]  <= 1'b1;
                if (clr_en) valid_q[hit_idx] <= 1'b0;
            end
            count_q  <= count_d;
            victim_q <= victim_d;

            read_valid          <= search_done;
            hit                 <= search_done && hit_any;
            write_error         <= werr_d;
            invalid_write_state <= inv_d;
            full                <= full_d;
            almost_full         <= af_d;
            if (search_done) begin
                dout      <= hit_any ? data_q[hit_idx] : '0;
                hit_index <= hit_any ? hit_idx : '0;
            end
        end
    end

    // Key/data payload needs no reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            keys_q[wr_idx] <= key_q;
            data_q[wr_idx] <= din_q;
        end
    end

endmodule

// File: tb/tb_cam_mem_ctrl.sv
// Directed bench for cam_mem_ctrl: one DEPTH=4 instance without replacement, one with round-robin replacement.
module tb_cam_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_a  [2];
    logic [1:0]  op_a   [2];
    logic [7:0]  key_a  [2];
    logic [15:0] din_a  [2];
    logic [15:0] dout_a [2];
    logic        rv_a   [2];
    logic        hit_a  [2];
    logic [1:0]  idx_a  [2];
    logic        busy_a [2];
    logic        full_a [2];
    logic        af_a   [2];
    logic        werr_a [2];
    logic        inv_a  [2];
    logic [1:0]  st_a   [2];

    int checks = 0;
    int errors = 0;
    int rv_cnt;

    cam_mem_ctrl #(.WIDTH_KEY(8), .WIDTH_DATA(16), .DEPTH(4), .AFULL_THRESH(2), .REPLACE_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_a[0]), .op(op_a[0]), .key(key_a[0]), .din(din_a[0]),
        .dout(dout_a[0]), .read_valid(rv_a[0]), .hit(hit_a[0]), .hit_index(idx_a[0]),
        .busy(busy_a[0]), .full(full_a[0]), .almost_full(af_a[0]), .write_error(werr_a[0]),
        .invalid_write_state(inv_a[0]), .state_dbg(st_a[0])
    );

    cam_mem_ctrl #(.WIDTH_KEY(8), .WIDTH_DATA(16), .DEPTH(4), .AFULL_THRESH(2), .REPLACE_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_a[1]), .op(op_a[1]), .key(key_a[1]), .din(din_a[1]),
        .dout(dout_a[1]), .read_valid(rv_a[1]), .hit(hit_a[1]), .hit_index(idx_a[1]),
        .busy(busy_a[1]), .full(full_a[1]), .almost_full(af_a[1]), .write_error(werr_a[1]),
        .invalid_write_state(inv_a[1]), .state_dbg(st_a[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one request, then wait until just after the commit edge (T+2).
    task automatic do_op(input int u, input logic [1:0] o, input logic [7:0] k, input logic [15:0] d);
        @(negedge clk);
        req_a[u] = 1'b1; op_a[u] = o; key_a[u] = k; din_a[u] = d;
        @(negedge clk);
        req_a[u] = 1'b0;
        chk("busy_after_accept", busy_a[u], 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("busy_after_commit", busy_a[u], 1'b0);
    endtask

    task automatic search_chk(input int u, input logic [7:0] k, input logic e_hit,
                              input logic [1:0] e_idx, input logic [15:0] e_dout);
        do_op(u, 2'b00, k, 16'h0);
        chk("search_read_valid", rv_a[u], 1'b1);
        chk("search_hit", hit_a[u], e_hit);
        chk("search_hit_index", idx_a[u], e_idx);
        chk("search_dout", dout_a[u], e_dout);
    endtask

    task automatic flags_chk(input int u, input logic e_full, input logic e_af);
        chk("full", full_a[u], e_full);
        chk("almost_full", af_a[u], e_af);
    endtask

    task automatic quiet_chk(input int u);
        @(negedge clk);
        chk("read_valid_clear", rv_a[u], 1'b0);
        chk("write_error_clear", werr_a[u], 1'b0);
        chk("invalid_write_clear", inv_a[u], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            req_a[u] = 1'b0; op_a[u] = 2'b00; key_a[u] = 8'h0; din_a[u] = 16'h0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_busy", busy_a[u], 1'b0);
            chk("rst_read_valid", rv_a[u], 1'b0);
            chk("rst_hit", hit_a[u], 1'b0);
            chk("rst_hit_index", idx_a[u], 2'd0);
            chk("rst_dout", dout_a[u], 16'h0);
            chk("rst_write_error", werr_a[u], 1'b0);
            chk("rst_invalid_write", inv_a[u], 1'b0);
            flags_chk(u, 1'b0, 1'b0);
        end
        rst = 1'b1;

        // No-replace instance: basic write then search.
        do_op(0, 2'b01, 8'h11, 16'hAAAA);
        flags_chk(0, 1'b0, 1'b0);
        search_chk(0, 8'h11, 1'b1, 2'd0, 16'hAAAA);
        quiet_chk(0);
        chk("dout_holds", dout_a[0], 16'hAAAA);

        do_op(0, 2'b01, 8'h22, 16'hBBBB);
        flags_chk(0, 1'b0, 1'b1);
        do_op(0, 2'b01, 8'h33, 16'h3333);
        flags_chk(0, 1'b0, 1'b1);
        do_op(0, 2'b01, 8'h44, 16'h4444);
        flags_chk(0, 1'b1, 1'b1);

        do_op(0, 2'b01, 8'h55, 16'h5555);
        chk("full_write_error", werr_a[0], 1'b1);
        flags_chk(0, 1'b1, 1'b1);
        quiet_chk(0);
        search_chk(0, 8'h55, 1'b0, 2'd0, 16'h0);
        search_chk(0, 8'h44, 1'b1, 2'd3, 16'h4444);
        search_chk(0, 8'h11, 1'b1, 2'd0, 16'hAAAA);

        do_op(0, 2'b10, 8'h22, 16'h0);
        chk("delete_hit_no_inv", inv_a[0], 1'b0);
        flags_chk(0, 1'b0, 1'b1);
        do_op(0, 2'b01, 8'h66, 16'hCCCC);
        flags_chk(0, 1'b1, 1'b1);
        search_chk(0, 8'h66, 1'b1, 2'd1, 16'hCCCC);
        search_chk(0, 8'h22, 1'b0, 2'd0, 16'h0);

        do_op(0, 2'b10, 8'h77, 16'h0);
        chk("delete_miss_inv", inv_a[0], 1'b1);
        flags_chk(0, 1'b1, 1'b1);
        quiet_chk(0);

        do_op(0, 2'b01, 8'h33, 16'hDDDD);
        chk("update_no_error", werr_a[0], 1'b0);
        flags_chk(0, 1'b1, 1'b1);
        search_chk(0, 8'h33, 1'b1, 2'd2, 16'hDDDD);
        do_op(0, 2'b10, 8'h33, 16'h0);
        flags_chk(0, 1'b0, 1'b1);

        // req held for 6 cycles: accepts at T and T+3 only.
        rv_cnt = 0;
        @(negedge clk);
        req_a[0] = 1'b1; op_a[0] = 2'b00; key_a[0] = 8'h11;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv_a[0]) rv_cnt++;
        end
        req_a[0] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv_a[0]) rv_cnt++;
        end
        chk("held_req_ops", rv_cnt, 2);

        // Replace instance: fill, then five misses walk the victim pointer 0,1,2,3,0.
        do_op(1, 2'b01, 8'h10, 16'h0010);
        do_op(1, 2'b01, 8'h20, 16'h0020);
        flags_chk(1, 1'b0, 1'b1);
        do_op(1, 2'b01, 8'h30, 16'h0030);
        do_op(1, 2'b01, 8'h40, 16'h0040);
        flags_chk(1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            do_op(1, 2'b01, 8'h50 + 8'(k), 16'h0500 + 16'(k));
            chk("replace_no_error", werr_a[1], 1'b0);
        end
        flags_chk(1, 1'b1, 1'b1);
        search_chk(1, 8'h54, 1'b1, 2'd0, 16'h0504);
        search_chk(1, 8'h51, 1'b1, 2'd1, 16'h0501);
        search_chk(1, 8'h52, 1'b1, 2'd2, 16'h0502);
        search_chk(1, 8'h53, 1'b1, 2'd3, 16'h0503);
        search_chk(1, 8'h10, 1'b0, 2'd0, 16'h0);
        search_chk(1, 8'h50, 1'b0, 2'd0, 16'h0);

        do_op(1, 2'b11, 8'h0, 16'h0);
        flags_chk(1, 1'b0, 1'b0);
        search_chk(1, 8'h51, 1'b0, 2'd0, 16'h0);
        do_op(1, 2'b01, 8'h60, 16'h6060);
        search_chk(1, 8'h60, 1'b1, 2'd0, 16'h6060);

        // Reset asserted while a write sits in MATCH.
        @(negedge clk);
        req_a[0] = 1'b1; op_a[0] = 2'b01; key_a[0] = 8'h99; din_a[0] = 16'h1234;
        @(negedge clk);
        req_a[0] = 1'b0;
        chk("in_match_busy", busy_a[0], 1'b1);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy_a[0], 1'b0);
        flags_chk(0, 1'b0, 1'b0);
        chk("midrst_read_valid", rv_a[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("postrst_write_error", werr_a[0], 1'b0);
            chk("postrst_read_valid", rv_a[0], 1'b0);
            chk("postrst_busy", busy_a[0], 1'b0);
        end
        search_chk(0, 8'h99, 1'b0, 2'd0, 16'h0);
        search_chk(0, 8'h11, 1'b0, 2'd0, 16'h0);
        flags_chk(0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_mem_ctrl.md
# cam_mem_ctrl

Parametrised content-addressable memory controller: the next-generation CAM behind the memory drive interface. It stores DEPTH key/data pairs and supports search, write/update, delete and flush through a single req/busy handshake. It reports full/almost_full occupancy and has an optional round-robin replacement mode. It sits between the test/driver request port and on-chip register storage.

## Interface
Parameters:
- WIDTH_KEY, 8, key (search tag) width
- WIDTH_DATA, 16, stored data width
- DEPTH, 16, number of entries (≥2, any integer)
- AFULL_THRESH, 2, almost_full when free entries ≤ AFULL_THRESH
- REPLACE_MODE, 0, 0 = write-miss on full is an error; 1 = overwrite round-robin victim

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled when busy=0
- op  in  2  00 search, 01 write, 10 delete, 11 flush
- key  in  WIDTH_KEY  lookup/write key
- din  in  WIDTH_DATA  write data
- dout  out  WIDTH_DATA  search result data
- read_valid  out  1  one-cycle pulse: search result valid
- hit  out  1  key matched (qualified by read_valid)
- hit_index  out  $clog2(DEPTH)  matched entry index
- busy  out  1  operation in flight; req ignored
- full  out  1  all DEPTH entries valid
- almost_full  out  1  free entries ≤ AFULL_THRESH
- write_error  out  1  one-cycle pulse: write miss while full, REPLACE_MODE=0
- invalid_write_state  out  1  one-cycle pulse: delete of absent key

## Operation
- FSM states: IDLE → MATCH → COMMIT → IDLE. busy = (state != IDLE), combinational from state.
- IDLE: on req=1, latch op/key/din, go to MATCH. req while busy is dropped; no flag is raised.
- MATCH: compare latched key against every valid entry; register the match vector; go to COMMIT.
- COMMIT: perform the action, register the result outputs, return to IDLE.
- Search hit: dout=entry data, hit=1, hit_index=index. Search miss: dout=0, hit=0, hit_index=0. read_valid pulses in both cases.
- Write hit: update data in place; count unchanged (no duplicate keys exist).
- Write miss, not full: allocate the lowest-index free entry; count+1.
- Write miss, full, REPLACE_MODE=0: no change; write_error pulse.
- Write miss, full, REPLACE_MODE=1: overwrite the entry at victim_ptr; victim_ptr increments and wraps DEPTH-1→0.
- Delete hit: clear the valid bit; count-1. Delete miss: invalid_write_state pulse; no change.
- Flush: clear all valid bits, count=0, victim_ptr=0.
- Multiple matches cannot occur by construction. If they do, the lowest index wins.
- Occupancy count is $clog2(DEPTH+1) bits.
  - full = (count == DEPTH)
  - almost_full = (DEPTH - count ≤ AFULL_THRESH)
  - Both flags are registered and update at the same edge as the commit.

## Timing
- Reset (rst=0, async): state IDLE, all valid bits 0, count 0, victim_ptr 0. dout, read_valid, hit, hit_index, write_error, invalid_write_state, busy and full are 0. almost_full = (DEPTH ≤ AFULL_THRESH).
- Reset mid-operation aborts the op: no result pulse, storage cleared.
- Accept at edge T. MATCH occupies T..T+1; COMMIT ends at T+2.
- Result outputs and flags are visible after edge T+2 and held for exactly one cycle. Pulse outputs return to 0 after edge T+3.
- busy is high after T through edge T+2. The earliest next accept is edge T+3, giving 1 op per 3 cycles.
- dout and hit_index hold their last value until the next search commit. Only the pulse outputs self-clear.

## Structure
- Package cam_pkg holds:
  - the op_e enum (OP_SEARCH, OP_WRITE, OP_DELETE, OP_FLUSH)
  - the state_e enum (IDLE, MATCH, COMMIT)
  - a localparam function for the index width.
- Sub-module cam_prio_enc: parametrised lowest-index priority encoder (vector → index + any). It is instantiated twice: once for the hit index and once for the free slot.
- Storage is flat register arrays: key, data and valid per entry.

## Test plan
- DEPTH=4: write (0x11,0xAAAA), then search 0x11 → read_valid=1, hit=1, hit_index=0, dout=0xAAAA, 2 cycles after accept.
- Write 4 distinct keys → full=1. almost_full (thresh 2) rises after the 2nd write. A 5th write with REPLACE_MODE=0 → write_error pulse and contents unchanged.
- REPLACE_MODE=1, full: write keys 0x50, 0x51, 0x52, 0x53, 0x54 → they overwrite indices 0,1,2,3,0 (victim wrap). Search of the first original key → hit=0.
- Delete key at index 1 → count 3, full=0. The next new write lands at index 1. Delete of absent key 0x77 → invalid_write_state pulse.
- req held high for 6 cycles → exactly 2 ops accepted (edges T and T+3). Write to an existing key updates data and count is unchanged.
- Assert rst during MATCH of a write → no pulses, all flags 0. A subsequent search of that key → hit=0.
